fft64_seq: RTL and testbench
============================

# fft64_seq

Control sequencer for the 64-point radix-4 DIF FFT. It steps the shared 4-input radix-4 butterfly through 3 stages of 16 butterflies each. For every butterfly it issues four in-place memory read addresses and three twiddle indices. It then issues the matching write-back strobe after the fixed datapath latency. The block contains no data path; it drives the sample RAM, the twiddle ROM and the butterfly pipeline enables.

## Interface
Parameters:
- RD_LAT, 1, sample-RAM read latency in cycles (≥0)
- BF_LAT, 1, butterfly plus twiddle-multiply pipeline depth (≥0); LAT = RD_LAT+BF_LAT must be ≥1

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a transform; sampled only in IDLE
- hold  in  1  freeze sequencer and delay line for this cycle
- busy  out  1  transform in progress
- done  out  1  one-cycle pulse after last write-back
- stage  out  2  current issue stage, 0..2
- rd_en  out  1  read/issue strobe for one butterfly
- rd_addr0..rd_addr3  out  6 each  butterfly input addresses
- tw_idx1..tw_idx3  out  6 each  twiddle exponents for outputs 1..3 (output 0 unrotated)
- wr_en  out  1  write-back strobe
- wr_addr0..wr_addr3  out  6 each  write-back addresses (in place)

## Operation
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE→RUN on start.
  - RUN issues 16 butterflies (bfly counter 0..15), then goes to DRAIN.
  - DRAIN waits LAT cycles. It then goes to RUN with stage+1, or to DONE if stage=2.
  - DONE lasts one cycle, asserts done, then returns to IDLE.
- Address generation for stage s and butterfly b:
  - span = 16>>(2s), giving 16, 4, 1.
  - pos = b mod span; grp = b / span.
  - base = grp·4·span + pos.
  - rd_addrk = base + k·span.
- Twiddle generation: tw_idxk = (k·pos·4^s) mod 64. All arithmetic is unsigned 6-bit.
- Write-back path: rd_en and the four addresses enter a LAT-deep delay line. Its output drives wr_en and wr_addr0..3.
- Any start pulse outside IDLE is ignored; this includes a start in the DONE cycle.
- hold=1:
  - State, counters and delay line keep their values.
  - rd_en and wr_en are forced to 0 that cycle.
  - busy keeps its value; done is delayed if hold falls in the DONE cycle.
- Reset values (asynchronous, including mid-transform):
  - state=IDLE, counters=0, delay line cleared.
  - All outputs 0; busy=0, done=0.
  - No pending write survives reset.
- Output ordering: output data is base-4 digit-reversed. Reordering belongs to the unload logic, not to this block.

## Timing
- Cycle 0 is the edge where start is sampled in IDLE.
- Stage s issues rd_en on cycles 1+s·(16+LAT) through 16+s·(16+LAT), one per cycle, with no gaps unless hold is asserted.
- A rd_en issued in cycle c produces wr_en in cycle c+LAT, counting non-held cycles only.
- DRAIN guarantees that the first read of stage s+1 follows the last write of stage s by at least one cycle. The RAM is assumed to commit writes at the clock edge.
- done fires in cycle 49+3·LAT. With the defaults (LAT=2), done fires in cycle 55.
- busy is 1 from cycle 1 through the done cycle inclusive.
- stage, rd_addr* and tw_idx* are registered. They are valid whenever rd_en=1 and hold their last value otherwise.

## Structure
- The shared package fft64_pkg holds:
  - N=64, ADDR_W=6, NBFLY=16, NSTAGE=3
  - the state enum
  - the twiddle index width
- Sub-module fft64_agu is a combinational address and twiddle generator. Inputs are (stage, bfly); outputs are 4 addresses and 3 twiddle indices.
- The top level holds the FSM, the counters and the parameterised delay line.

## Test plan
- Defaults, single start: stage-0 b=5 gives rd_addr 5,21,37,53 and tw 0,5,10,15. b=15 gives tw 0,15,30,45. done is a single pulse at cycle 55. Exactly 48 rd_en and 48 wr_en over the transform.
- Stage 1, b=6: rd_addr 18,22,26,30 and tw 0,8,16,24. Stage 2, b=7: rd_addr 28,29,30,31 and tw 0,0,0.
- Hazard check: in every stage the last wr_en precedes the next stage's first rd_en by at least one cycle. Each wr_addr set equals the rd_addr set from LAT cycles earlier. Repeat with RD_LAT=2, BF_LAT=3 (done at cycle 64).
- hold asserted for 3 cycles mid stage 1: no strobes during hold. Resumes at the same bfly with no skipped or duplicated addresses. done moves 3 cycles later, to cycle 58.
- start pulsed during RUN and in the DONE cycle: ignored; the transform count stays 1. Back-to-back start in IDLE right after done: the new transform begins normally.
- rst asserted in stage 2 with the delay line full: all outputs go to 0 immediately with no later wr_en. A following start runs a complete transform from stage 0, b=0.

Source files
------------

// File: rtl/fft64_pkg.sv
// Shared constants and types for the 64-point radix-4 DIF FFT sequencer.
package fft64_pkg;

  localparam int unsigned N      = 64;
  localparam int unsigned ADDR_W = 6;
  localparam int unsigned NBFLY  = 16;
  localparam int unsigned NSTAGE = 3;
  localparam int unsigned TW_W   = 6;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } state_e;

  // One slot of the write-back delay line: strobe plus the four in-place addresses.
  typedef struct packed {
    logic              en;
    logic [ADDR_W-1:0] a0;
    logic [ADDR_W-1:0] a1;
    logic [ADDR_W-1:0] a2;
    logic [ADDR_W-1:0] a3;
  } wb_t;

endpackage

// File: rtl/fft64_agu.sv
// Combinational address / twiddle generator for one radix-4 butterfly.
// span = 16 >> 2*stage, pos = bfly mod span, base = grp*4*span + pos.
module fft64_agu
  import fft64_pkg::*;
(
  input  logic [1:0]        stage,
  input  logic [3:0]        bfly,
  output logic [ADDR_W-1:0] addr0,
  output logic [ADDR_W-1:0] addr1,
  output logic [ADDR_W-1:0] addr2,
  output logic [ADDR_W-1:0] addr3,
  output logic [TW_W-1:0]   tw1,
  output logic [TW_W-1:0]   tw2,
  output logic [TW_W-1:0]   tw3
);

  logic [ADDR_W-1:0] span;
  logic [ADDR_W-1:0] base;
  logic [TW_W-1:0]   rot;

  // Span is a power of four, so mod/div reduce to bit slicing of bfly.
  always_comb begin
    span = '0;
    base = '0;
    rot  = '0;
    case (stage)
      2'd0: begin
        span = 6'd16;
        base = {2'b00, bfly};
        rot  = {2'b00, bfly};
      end
      2'd1: begin
        span = 6'd4;
        base = {bfly[3:2], 2'b00, bfly[1:0]};
        rot  = {2'b00, bfly[1:0], 2'b00};
      end
      2'd2: begin
        span = 6'd1;
        base = {bfly, 2'b00};
        rot  = '0;
      end
      default: begin
        span = '0;
        base = '0;
        rot  = '0;
      end
    endcase
  end

  // Addresses step by span; twiddles are k*rot, all wrapping modulo 64.
  always_comb begin
    addr0 = base;
    addr1 = base + span;
    addr2 = base + (span << 1);
    addr3 = base + span + (span << 1);
    tw1   = rot;
    tw2   = rot << 1;
    tw3   = rot + (rot << 1);
  end

endmodule

// File: rtl/fft64_seq.sv
// Control sequencer for the 64-point radix-4 DIF FFT: 3 stages x 16 butterflies,
// read issue with registered addresses/twiddles, and a LAT-deep write-back delay line.
module fft64_seq
  import fft64_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int BF_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              hold,
  output logic              busy,
  output logic              done,
  output logic [1:0]        stage,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr0,
  output logic [ADDR_W-1:0] rd_addr1,
  output logic [ADDR_W-1:0] rd_addr2,
  output logic [ADDR_W-1:0] rd_addr3,
  output logic [TW_W-1:0]   tw_idx1,
  output logic [TW_W-1:0]   tw_idx2,
  output logic [TW_W-1:0]   tw_idx3,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr0,
  output logic [ADDR_W-1:0] wr_addr1,
  output logic [ADDR_W-1:0] wr_addr2,
  output logic [ADDR_W-1:0] wr_addr3
);

  localparam int LAT = RD_LAT + BF_LAT;

  state_e            state;
  logic [3:0]        bfly;
  logic [1:0]        stg;
  logic [7:0]        dcnt;
  logic              rd_q;
  logic              done_q;
  logic              busy_q;
  logic [1:0]        stage_q;
  logic [ADDR_W-1:0] ra0_q, ra1_q, ra2_q, ra3_q;
  logic [TW_W-1:0]   tw1_q, tw2_q, tw3_q;
  wb_t               dly [LAT];

  logic [ADDR_W-1:0] a0, a1, a2, a3;
  logic [TW_W-1:0]   t1, t2, t3;

  fft64_agu u_agu (
    .stage (stg),
    .bfly  (bfly),
    .addr0 (a0),
    .addr1 (a1),
    .addr2 (a2),
    .addr3 (a3),
    .tw1   (t1),
    .tw2   (t2),
    .tw3   (t3)
  );

  // FSM, counters, registered issue outputs and write-back delay line; hold freezes all.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= StIdle;
      bfly    <= '0;
      stg     <= '0;
      dcnt    <= '0;
      rd_q    <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      stage_q <= '0;
      ra0_q   <= '0;
      ra1_q   <= '0;
      ra2_q   <= '0;
      ra3_q   <= '0;
      tw1_q   <= '0;
      tw2_q   <= '0;
      tw3_q   <= '0;
      for (int i = 0; i < LAT; i++) dly[i] <= '0;
    end else if (!hold) begin
      rd_q <= 1'b0;
      case (state)
        StIdle: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          if (start) begin
            state <= StRun;
            bfly  <= '0;
            stg   <= '0;
          end
        end
        StRun: begin
          busy_q  <= 1'b1;
          rd_q    <= 1'b1;
          stage_q <= stg;
          ra0_q   <= a0;
          ra1_q   <= a1;
          ra2_q   <= a2;
          ra3_q   <= a3;
          tw1_q   <= t1;
          tw2_q   <= t2;
          tw3_q   <= t3;
          bfly    <= bfly + 4'd1;
          if (bfly == 4'(NBFLY - 1)) begin
            state <= StDrain;
            dcnt  <= '0;
          end
        end
        StDrain: begin
          // Wait until the last write of this stage has left the delay line.
          if (dcnt == 8'(LAT - 1)) begin
            dcnt <= '0;
            if (stg == 2'(NSTAGE - 1)) begin
              state <= StDone;
            end else begin
              stg   <= stg + 2'd1;
              state <= StRun;
            end
          end else begin
            dcnt <= dcnt + 8'd1;
          end
        end
        StDone: begin
          // First pass raises done; second pass drops it and releases busy.
          if (!done_q) begin
            done_q <= 1'b1;
          end else begin
            done_q <= 1'b0;
            busy_q <= 1'b0;
            state  <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
      dly[0] <= '{en: rd_q, a0: ra0_q, a1: ra1_q, a2: ra2_q, a3: ra3_q};
      for (int i = 1; i < LAT; i++) dly[i] <= dly[i-1];
    end
  end

  // Strobes and done are masked during a held cycle so nothing is issued twice.
  always_comb begin
    busy     = busy_q;
    done     = done_q & ~hold;
    stage    = stage_q;
    rd_en    = rd_q & ~hold;
    rd_addr0 = ra0_q;
    rd_addr1 = ra1_q;
    rd_addr2 = ra2_q;
    rd_addr3 = ra3_q;
    tw_idx1  = tw1_q;
    tw_idx2  = tw2_q;
    tw_idx3  = tw3_q;
    wr_en    = dly[LAT-1].en & ~hold;
    wr_addr0 = dly[LAT-1].a0;
    wr_addr1 = dly[LAT-1].a1;
    wr_addr2 = dly[LAT-1].a2;
    wr_addr3 = dly[LAT-1].a3;
  end

endmodule

// File: tb/tb_fft64_seq.sv
// Bench for fft64_seq: instance 0 uses the defaults (LAT=2), instance 1 uses RD_LAT=2, BF_LAT=3.
module tb_fft64_seq;
  import fft64_pkg::*;

  typedef struct packed {
    logic [23:0] a;
    int          u;
    int          s;
  } pend_t;

  typedef struct {
    int          s;
    int          b;
    logic [23:0] a;
    logic [17:0] t;
  } vec_t;

  localparam int NV = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rst, start, hold, busy, done, rd_en, wr_en;
  logic [1:0] stg [2];
  logic [5:0] ra  [2][4];
  logic [5:0] tw  [2][3];
  logic [5:0] wa  [2][4];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    fft64_seq #(
      .RD_LAT (g == 0 ? 1 : 2),
      .BF_LAT (g == 0 ? 1 : 3)
    ) dut (
      .clk      (clk),
      .rst      (rst[g]),
      .start    (start[g]),
      .hold     (hold[g]),
      .busy     (busy[g]),
      .done     (done[g]),
      .stage    (stg[g]),
      .rd_en    (rd_en[g]),
      .rd_addr0 (ra[g][0]),
      .rd_addr1 (ra[g][1]),
      .rd_addr2 (ra[g][2]),
      .rd_addr3 (ra[g][3]),
      .tw_idx1  (tw[g][0]),
      .tw_idx2  (tw[g][1]),
      .tw_idx3  (tw[g][2]),
      .wr_en    (wr_en[g]),
      .wr_addr0 (wa[g][0]),
      .wr_addr1 (wa[g][1]),
      .wr_addr2 (wa[g][2]),
      .wr_addr3 (wa[g][3])
    );
  end

  int n_chk  = 0;
  int n_fail = 0;
  int edge_n = 0;
  int start_edge [2];
  bit mon_on [2];
  int lat [2];
  int rd_cnt [2], wr_cnt [2], done_cnt [2], done_cyc [2], ucnt [2];
  int exp_s [2], exp_b [2];
  int first_rd [2][3];
  int last_wr  [2][3];
  logic [23:0] obs_a [2][48];
  logic [17:0] obs_t [2][48];
  pend_t q0 [$];
  pend_t q1 [$];
  vec_t vt [NV];

  int          m_cyc, m_span, m_pos, m_grp, m_base, m_rot;
  logic [23:0] m_ea, m_act;
  logic [17:0] m_et;
  pend_t       m_p;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) edge_n++;

  // Per-cycle monitor: independent address model, write-back scoreboard, event log.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (mon_on[i]) begin
        m_cyc = edge_n - start_edge[i];
        if (rd_en[i]) begin
          if (exp_s[i] > 2) begin
            chk("rd_extra_stage", exp_s[i], 2);
          end else begin
            m_span = 16 >> (2 * exp_s[i]);
            m_pos  = exp_b[i] % m_span;
            m_grp  = exp_b[i] / m_span;
            m_base = m_grp * 4 * m_span + m_pos;
            m_rot  = m_pos * (1 << (2 * exp_s[i]));
            m_ea   = {6'(m_base), 6'(m_base + m_span), 6'(m_base + 2 * m_span),
                      6'(m_base + 3 * m_span)};
            m_et   = {6'(m_rot), 6'(2 * m_rot), 6'(3 * m_rot)};
            m_act  = {ra[i][0], ra[i][1], ra[i][2], ra[i][3]};
            chk("rd_stage", int'(stg[i]), exp_s[i]);
            chk("rd_addr", int'(m_act), int'(m_ea));
            chk("tw_idx", int'({tw[i][0], tw[i][1], tw[i][2]}), int'(m_et));
            obs_a[i][exp_s[i] * 16 + exp_b[i]] = m_act;
            obs_t[i][exp_s[i] * 16 + exp_b[i]] = {tw[i][0], tw[i][1], tw[i][2]};
            if (exp_b[i] == 0) first_rd[i][exp_s[i]] = m_cyc;
            m_p.a = m_act;
            m_p.u = ucnt[i];
            m_p.s = exp_s[i];
            if (i == 0) q0.push_back(m_p);
            else q1.push_back(m_p);
            exp_b[i]++;
            if (exp_b[i] == 16) begin
              exp_b[i] = 0;
              exp_s[i]++;
            end
          end
          rd_cnt[i]++;
        end
        if (wr_en[i]) begin
          if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
            chk("wr_without_rd", wr_cnt[i] + 1, rd_cnt[i]);
          end else begin
            if (i == 0) m_p = q0.pop_front();
            else m_p = q1.pop_front();
            chk("wr_addr", int'({wa[i][0], wa[i][1], wa[i][2], wa[i][3]}), int'(m_p.a));
            chk("wr_latency", ucnt[i] - m_p.u, lat[i]);
            last_wr[i][m_p.s] = m_cyc;
          end
          wr_cnt[i]++;
        end
        if (done[i]) begin
          done_cnt[i]++;
          done_cyc[i] = m_cyc;
          chk("busy_at_done", int'(busy[i]), 1);
        end
        if (!hold[i]) ucnt[i]++;
      end
    end
  end

  // Called just after a rising edge: start is sampled at the next edge (cycle 0).
  task automatic begin_run(input int i);
    start_edge[i] = edge_n + 1;
    rd_cnt[i]     = 0;
    wr_cnt[i]     = 0;
    done_cnt[i]   = 0;
    done_cyc[i]   = -1;
    ucnt[i]       = 0;
    exp_s[i]      = 0;
    exp_b[i]      = 0;
    for (int s = 0; s < 3; s++) begin
      first_rd[i][s] = -1;
      last_wr[i][s]  = -1;
    end
    for (int k = 0; k < 48; k++) begin
      obs_a[i][k] = '0;
      obs_t[i][k] = '0;
    end
    if (i == 0) q0.delete();
    else q1.delete();
    mon_on[i] = 1'b1;
    start[i]  = 1'b1;
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_done(input int i, input int budget);
    int n = 0;
    while (done_cnt[i] == 0 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (done_cnt[i] == 0) chk("done_timeout", done_cnt[i], 1);
  endtask

  task automatic check_table(input int i);
    for (int k = 0; k < NV; k++) begin
      chk($sformatf("tbl%0d_s%0d_b%0d_addr", k, vt[k].s, vt[k].b),
          int'(obs_a[i][vt[k].s * 16 + vt[k].b]), int'(vt[k].a));
      chk($sformatf("tbl%0d_s%0d_b%0d_tw", k, vt[k].s, vt[k].b),
          int'(obs_t[i][vt[k].s * 16 + vt[k].b]), int'(vt[k].t));
    end
  endtask

  task automatic check_run(input int i, input int exp_done);
    chk("done_cycle", done_cyc[i], exp_done);
    chk("done_pulses", done_cnt[i], 1);
    chk("rd_count", rd_cnt[i], 48);
    chk("wr_count", wr_cnt[i], 48);
    chk("busy_after", int'(busy[i]), 0);
  endtask

  int act_cnt;

  initial begin
    vt[0] = '{0, 0,  {6'd0,  6'd16, 6'd32, 6'd48}, {6'd0,  6'd0,  6'd0}};
    vt[1] = '{0, 5,  {6'd5,  6'd21, 6'd37, 6'd53}, {6'd5,  6'd10, 6'd15}};
    vt[2] = '{0, 15, {6'd15, 6'd31, 6'd47, 6'd63}, {6'd15, 6'd30, 6'd45}};
    vt[3] = '{1, 0,  {6'd0,  6'd4,  6'd8,  6'd12}, {6'd0,  6'd0,  6'd0}};
    vt[4] = '{1, 5,  {6'd17, 6'd21, 6'd25, 6'd29}, {6'd4,  6'd8,  6'd12}};
    vt[5] = '{1, 6,  {6'd18, 6'd22, 6'd26, 6'd30}, {6'd8,  6'd16, 6'd24}};
    vt[6] = '{1, 15, {6'd51, 6'd55, 6'd59, 6'd63}, {6'd12, 6'd24, 6'd36}};
    vt[7] = '{2, 7,  {6'd28, 6'd29, 6'd30, 6'd31}, {6'd0,  6'd0,  6'd0}};
    vt[8] = '{2, 15, {6'd60, 6'd61, 6'd62, 6'd63}, {6'd0,  6'd0,  6'd0}};
    lat[0]    = 2;
    lat[1]    = 5;
    mon_on[0] = 1'b0;
    mon_on[1] = 1'b0;
    rst   = 2'b00;
    start = 2'b00;
    hold  = 2'b00;
    #2 rst = 2'b11;
    step(2);
    rst = 2'b00;

    // Reset state
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_rd_en", int'(rd_en), 0);
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_stage", int'(stg[0]), 0);
    chk("rst_rd_addr", int'({ra[0][0], ra[0][1], ra[0][2], ra[0][3]}), 0);
    chk("rst_tw", int'({tw[0][0], tw[0][1], tw[0][2]}), 0);
    chk("rst_wr_addr", int'({wa[1][0], wa[1][1], wa[1][2], wa[1][3]}), 0);

    // A: clean transform on both instances
    step(1);
    begin_run(0);
    begin_run(1);
    step(1);
    start = 2'b00;
    chk("busy_cycle0", int'(busy[0]), 0);
    step(1);
    chk("busy_cycle1", int'(busy[0]), 1);
    chk("rd_cycle1", int'(rd_en[1]), 1);
    wait_done(0, 200);
    wait_done(1, 200);
    step(5);
    for (int i = 0; i < 2; i++) begin
      check_run(i, 49 + 3 * lat[i]);
      for (int s = 0; s < 3; s++) begin
        chk($sformatf("first_rd_d%0d_s%0d", i, s), first_rd[i][s], 1 + s * (16 + lat[i]));
        chk($sformatf("last_wr_d%0d_s%0d", i, s), last_wr[i][s], 16 + s * (16 + lat[i]) + lat[i]);
      end
      for (int s = 0; s < 2; s++)
        chk($sformatf("hazard_d%0d_s%0d", i, s),
            (first_rd[i][s+1] > last_wr[i][s]) ? 1 : 0, 1);
      check_table(i);
    end
    mon_on[1] = 1'b0;

    // B: hold 3 cycles mid stage 1, starts during RUN and in the done cycle are ignored
    begin_run(0);
    for (int c = 0; c <= 59; c++) begin
      step(1);
      start[0] = (c == 10 || c == 58);
      hold[0]  = (c >= 25 && c <= 27);
      if (hold[0]) begin
        #1;
        chk($sformatf("hold_rd_c%0d", c), int'(rd_en[0]), 0);
        chk($sformatf("hold_wr_c%0d", c), int'(wr_en[0]), 0);
      end
    end
    check_run(0, 58);

    // C: back-to-back start, then reset in stage 2 with writes in flight
    begin_run(0);
    step(1);
    start[0] = 1'b0;
    chk("b2b_busy_cycle0", int'(busy[0]), 0);
    step(45);
    chk("pre_rst_stage", int'(stg[0]), 2);
    chk("pre_rst_first_rd", first_rd[0][0], 1);
    mon_on[0] = 1'b0;
    rst[0] = 1'b1;
    #1;
    chk("async_rst_busy", int'(busy[0]), 0);
    chk("async_rst_rd_en", int'(rd_en[0]), 0);
    chk("async_rst_wr_en", int'(wr_en[0]), 0);
    chk("async_rst_stage", int'(stg[0]), 0);
    chk("async_rst_rd_addr", int'({ra[0][0], ra[0][1], ra[0][2], ra[0][3]}), 0);
    chk("async_rst_wr_addr", int'({wa[0][0], wa[0][1], wa[0][2], wa[0][3]}), 0);
    step(2);
    rst[0] = 1'b0;
    act_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      step(1);
      act_cnt += int'(rd_en[0]) + int'(wr_en[0]) + int'(done[0]) + int'(busy[0]);
    end
    chk("post_rst_activity", act_cnt, 0);

    // D: full transform after reset starts from stage 0, bfly 0
    begin_run(0);
    step(1);
    start[0] = 1'b0;
    wait_done(0, 200);
    step(3);
    check_run(0, 55);
    chk("post_rst_first_rd", first_rd[0][0], 1);
    check_table(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
